// File: rtl/regfile_wb.sv
// ============================================================================
// Module      : regfile_wb
// Description : 31x XLEN register file with a load/ALU writeback arbiter and a
//               one-entry deferred ALU write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            ld_wr_en,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_val,
    input  logic            alu_wr_en,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_val,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic            wb_stall
);

    logic [XLEN-1:0] regs_q [1:31];
    logic [XLEN-1:0] regs_d [1:31];

    logic            pend_valid_q, pend_valid_d;
    logic [4:0]      pend_rd_q,    pend_rd_d;
    logic [XLEN-1:0] pend_val_q,   pend_val_d;

    logic            alu_acc;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    assign wb_stall = pend_valid_q;
    assign alu_acc  = alu_wr_en && !pend_valid_q;

    // Single array write port: load first, then the deferred ALU entry,
    // then a freshly accepted ALU request.
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = '0;
        wr_data = '0;
        if (ld_wr_en) begin
            wr_en   = (ld_rd != 5'd0);
            wr_rd   = ld_rd;
            wr_data = ld_val;
        end else if (pend_valid_q) begin
            wr_en   = 1'b1;
            wr_rd   = pend_rd_q;
            wr_data = pend_val_q;
        end else if (alu_acc) begin
            wr_en   = (alu_rd != 5'd0);
            wr_rd   = alu_rd;
            wr_data = alu_val;
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_rd_d    = pend_rd_q;
        pend_val_d   = pend_val_q;
        if (pend_valid_q) begin
            if (!ld_wr_en) begin
                pend_valid_d = 1'b0;
            end
        end else if (ld_wr_en && alu_acc && (alu_rd != 5'd0)) begin
            pend_valid_d = 1'b1;
            pend_rd_d    = alu_rd;
            pend_val_d   = alu_val;
        end
    end

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = (wr_en && (wr_rd == 5'(i))) ? wr_data : regs_q[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            pend_val_q   <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            pend_val_q   <= pend_val_d;
        end
    end

    // The pending entry is younger than the array and any in-flight load, so
    // it wins the bypass; reset forces zero even while write inputs are live.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        logic [XLEN-1:0] arr;
        arr = '0;
        for (int i = 1; i < 32; i++) begin
            if (addr == 5'(i)) begin
                arr = regs_q[i];
            end
        end
        if (!i_rst_n || (addr == 5'd0)) begin
            return '0;
        end else if (pend_valid_q && (pend_rd_q == addr)) begin
            return pend_val_q;
        end else if (wr_en && (wr_rd == addr)) begin
            return wr_data;
        end
        return arr;
    endfunction

    assign rs1_val = read_port(rs1_addr);
    assign rs2_val = read_port(rs2_addr);

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb.sv
// ============================================================================
// Module      : tb_regfile_wb
// Description : Directed self-checking bench for regfile_wb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        ld_wr_en;
    logic [4:0]  ld_rd;
    logic [31:0] ld_val;
    logic        alu_wr_en;
    logic [4:0]  alu_rd;
    logic [31:0] alu_val;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        wb_stall;

    int checks   = 0;
    int failures = 0;

    regfile_wb #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .ld_wr_en (ld_wr_en),
        .ld_rd    (ld_rd),
        .ld_val   (ld_val),
        .alu_wr_en(alu_wr_en),
        .alu_rd   (alu_rd),
        .alu_val  (alu_val),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .wb_stall (wb_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_ld(input logic en, input logic [4:0] rd, input logic [31:0] v);
        ld_wr_en = en;
        ld_rd    = rd;
        ld_val   = v;
    endtask

    task automatic drive_alu(input logic en, input logic [4:0] rd, input logic [31:0] v);
        alu_wr_en = en;
        alu_rd    = rd;
        alu_val   = v;
    endtask

    task automatic rd_addr(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive_ld(1'b0, 5'd0, 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        rd_addr(5'd5, 5'd31);
        check("rst_stall", {31'b0, wb_stall}, 32'h0);
        check("rst_rs1", rs1_val, 32'h0);
        check("rst_rs2", rs2_val, 32'h0);
        tick();
        tick();
        #2 i_rst_n = 1'b1;
        tick();

        // Load write with same-cycle bypass, then array read
        drive_ld(1'b1, 5'd5, 32'hDEADBEEF);
        rd_addr(5'd5, 5'd6);
        check("ld_bypass", rs1_val, 32'hDEADBEEF);
        check("ld_other", rs2_val, 32'h0);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        rd_addr(5'd5, 5'd6);
        check("ld_array", rs1_val, 32'hDEADBEEF);

        // Load and ALU collide on different rd
        drive_ld(1'b1, 5'd3, 32'h11);
        drive_alu(1'b1, 5'd7, 32'h22);
        rd_addr(5'd3, 5'd7);
        check("col_ld_byp", rs1_val, 32'h11);
        check("col_stall0", {31'b0, wb_stall}, 32'h0);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        rd_addr(5'd3, 5'd7);
        check("col_stall1", {31'b0, wb_stall}, 32'h1);
        check("col_x3", rs1_val, 32'h11);
        check("col_pend_x7", rs2_val, 32'h22);
        tick();
        rd_addr(5'd3, 5'd7);
        check("col_stall_clr", {31'b0, wb_stall}, 32'h0);
        check("col_x7", rs2_val, 32'h22);

        // Same rd: ALU value is final
        drive_ld(1'b1, 5'd9, 32'hAAAA);
        drive_alu(1'b1, 5'd9, 32'h5555);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        rd_addr(5'd9, 5'd0);
        check("same_rd_c1", rs1_val, 32'h5555);
        check("same_rd_stall", {31'b0, wb_stall}, 32'h1);
        tick();
        rd_addr(5'd9, 5'd0);
        check("same_rd_c2", rs1_val, 32'h5555);
        tick();
        rd_addr(5'd9, 5'd0);
        check("same_rd_final", rs1_val, 32'h5555);

        // Pending entry plus second load and a held ALU request
        drive_ld(1'b1, 5'd2, 32'h20);
        drive_alu(1'b1, 5'd10, 32'hA0);
        tick();
        drive_ld(1'b1, 5'd4, 32'h44);
        drive_alu(1'b1, 5'd8, 32'h88);
        rd_addr(5'd4, 5'd10);
        check("hold_stall_a", {31'b0, wb_stall}, 32'h1);
        check("hold_x4_byp", rs1_val, 32'h44);
        check("hold_pend_x10", rs2_val, 32'hA0);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        rd_addr(5'd4, 5'd8);
        check("hold_stall_b", {31'b0, wb_stall}, 32'h1);
        check("hold_x4", rs1_val, 32'h44);
        check("hold_x8_not_yet", rs2_val, 32'h0);
        rd_addr(5'd10, 5'd2);
        check("hold_pend_wr_x10", rs1_val, 32'hA0);
        check("hold_x2", rs2_val, 32'h20);
        tick();
        rd_addr(5'd8, 5'd10);
        check("hold_stall_c", {31'b0, wb_stall}, 32'h0);
        check("hold_x8_byp", rs1_val, 32'h88);
        check("hold_x10", rs2_val, 32'hA0);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        rd_addr(5'd8, 5'd10);
        check("hold_x8", rs1_val, 32'h88);
        check("hold_stall_d", {31'b0, wb_stall}, 32'h0);

        // Writes to x0 are discarded and never pended
        drive_ld(1'b1, 5'd0, 32'hFFFFFFFF);
        drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        rd_addr(5'd0, 5'd0);
        check("x0_rs1_a", rs1_val, 32'h0);
        check("x0_rs2_a", rs2_val, 32'h0);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        rd_addr(5'd0, 5'd0);
        check("x0_no_pend", {31'b0, wb_stall}, 32'h0);
        check("x0_rs1_b", rs1_val, 32'h0);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        rd_addr(5'd0, 5'd0);
        check("x0_rs2_c", rs2_val, 32'h0);

        // Asynchronous reset while a write is pending
        drive_ld(1'b1, 5'd11, 32'h1111);
        drive_alu(1'b1, 5'd12, 32'h1212);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        rd_addr(5'd12, 5'd5);
        check("arst_pre_stall", {31'b0, wb_stall}, 32'h1);
        #1 i_rst_n = 1'b0;
        #1;
        check("arst_stall", {31'b0, wb_stall}, 32'h0);
        check("arst_x12", rs1_val, 32'h0);
        check("arst_x5", rs2_val, 32'h0);
        drive_ld(1'b1, 5'd13, 32'h77);
        rd_addr(5'd13, 5'd11);
        check("arst_byp_gated", rs1_val, 32'h0);
        check("arst_x11", rs2_val, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        tick();
        #2 i_rst_n = 1'b1;
        drive_ld(1'b1, 5'd13, 32'h13);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        rd_addr(5'd12, 5'd13);
        check("post_x12", rs1_val, 32'h0);
        check("post_first_edge", rs2_val, 32'h13);
        check("post_stall", {31'b0, wb_stall}, 32'h0);
        tick();
        rd_addr(5'd12, 5'd3);
        check("post_x12_b", rs1_val, 32'h0);
        check("post_x3", rs2_val, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
